// File: rtl/gate_sweep_checker.sv
// Sweeps a 2-input gate cell through all four input vectors, samples its output
// after a settle delay and reports pass/fail, mismatch count and per-vector mask.
//
// state | meaning
// IDLE  | waiting for start; invalid op reports an immediate failed done
// WAIT  | holding the current {a,b} vector while the cell settles
// CHECK | one cycle; compare f against the latched truth table, advance vector
module gate_sweep_checker #(
    parameter int SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       f,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_vec
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;

    state_t        state;
    logic [2:0]    op_q;
    logic [CW-1:0] cnt;
    logic          expected;
    logic          miss;
    logic [2:0]    err_next;

    always_comb begin
        expected = 1'b0;
        case (op_q)
            3'd0:    expected = a | b;
            3'd1:    expected = a & b;
            3'd2:    expected = ~(a | b);
            3'd3:    expected = ~(a & b);
            3'd4:    expected = a ^ b;
            3'd5:    expected = ~(a ^ b);
            default: expected = 1'b0;
        endcase
        miss     = f ^ expected;
        err_next = err_cnt + {2'b00, miss};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            cnt      <= '0;
            a        <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err_cnt  <= '0;
                        fail_vec <= '0;
                        pass     <= 1'b0;
                        if (op <= 3'd5) begin
                            op_q   <= op;
                            {a, b} <= 2'b00;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= WAIT;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CNT_LAST) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CHECK: begin
                    err_cnt <= err_next;
                    if (miss) begin
                        fail_vec[{a, b}] <= 1'b1;
                    end
                    if ({a, b} != 2'b11) begin
                        {a, b} <= {a, b} + 2'd1;
                        cnt    <= '0;
                        state  <= WAIT;
                    end else begin
                        // pass must reflect the comparison made on this same edge
                        pass   <= (err_next == 3'd0);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        {a, b} <= 2'b00;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: a configurable gate/pipe model drives f,
// expected sweep results are queued at start and checked whenever done pulses.
module tb_gate_sweep_checker;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic       f;
    logic       a, b, busy, done, pass;
    logic [2:0] err_cnt;
    logic [3:0] fail_vec;

    logic [2:0] gfun;
    logic [2:0] d_sel;
    logic [5:0] pipe;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    typedef struct {
        logic       p;
        logic [2:0] e;
        logic [3:0] fv;
        int         t;
    } exp_t;
    exp_t sbq[$];

    // truth tables indexed by {a,b}
    logic [3:0] tt [6] = '{4'b1110, 4'b1000, 4'b0001, 4'b0111, 4'b0110, 4'b1001};

    gate_sweep_checker #(.SETTLE(S)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .f(f),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_vec(fail_vec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // cell under test: gfun 0..5 are gates, 6 stuck-at-0, 7 stuck-at-1
    function automatic logic gate(input logic [2:0] g, input logic x, input logic y);
        case (g)
            3'd0: return x | y;
            3'd1: return x & y;
            3'd2: return !(x | y);
            3'd3: return !(x & y);
            3'd4: return x ^ y;
            3'd5: return x == y;
            3'd6: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[4:0], gate(gfun, a, b)};
    end

    always_comb begin
        f = gate(gfun, a, b);
        if (d_sel != 3'd0) f = pipe[d_sel - 3'd1];
    end

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Sample for vector k is taken at E0+(k+1)(S+1); a D-deep pipe shows the
    // vector that was applied during cycle E0+k(S+1)+S-D (00 before the sweep).
    function automatic exp_t model(input int opv, input int g, input int d, input int t);
        exp_t r;
        r.e = 0; r.fv = 0; r.t = t;
        if (opv > 5) begin
            r.p = 0;
            return r;
        end
        for (int k = 0; k < 4; k++) begin
            int   seen;
            int   sv;
            logic got;
            seen = k * (S + 1) + S - d;
            sv   = (seen < 0) ? 0 : seen / (S + 1);
            got  = gate(3'(g), sv[1], sv[0]);
            if (got != tt[opv][k]) begin
                r.e++;
                r.fv[k] = 1'b1;
            end
        end
        r.p = (r.e == 0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("done_cycle", cyc, e.t);
                check("pass", pass, e.p);
                check("err_cnt", err_cnt, e.e);
                check("fail_vec", fail_vec, e.fv);
                check("busy_at_done", busy, 0);
            end
        end
    end

    task automatic sweep(input int opv, input int g, input int d, input bit chop, input bit poke);
        gfun  = 3'(g);
        d_sel = 3'(d);
        repeat (7) @(negedge clk);
        op    = 3'(opv);
        start = 1'b1;
        sbq.push_back(model(opv, g, d, cyc + 1 + ((opv > 5) ? 0 : 4 * (S + 1))));
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, (opv <= 5) ? 1 : 0);
        if (opv <= 5) begin
            if (chop) op = 3'($urandom_range(0, 7));
            repeat (2) @(negedge clk);
            check("vector0", {a, b}, 0);
            for (int k = 1; k < 4; k++) begin
                if (poke) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    repeat (S) @(negedge clk);
                end else begin
                    repeat (S + 1) @(negedge clk);
                end
                check("vector", {a, b}, k);
            end
            repeat (6) @(negedge clk);
        end else begin
            check("busy_invalid", busy, 0);
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; op = '0; gfun = '0; d_sel = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {a, b, busy, done, pass, err_cnt, fail_vec}, 0);

        sweep(0, 0, 0, 0, 0);   // OR, correct cell
        sweep(0, 6, 0, 0, 0);   // OR, stuck-at-0
        sweep(3, 3, 4, 0, 0);   // NAND through 4-deep pipe
        sweep(3, 3, 5, 0, 0);   // NAND through 5-deep pipe
        sweep(7, 0, 0, 0, 0);   // invalid op
        sweep(2, 2, 0, 1, 0);   // NOR with op changed mid-sweep
        sweep(1, 1, 0, 0, 1);   // AND with start pulses while busy

        // reset 7 cycles into a sweep: everything clears and no done appears
        gfun = 3'd6; d_sel = 3'd0;
        repeat (7) @(negedge clk);
        op = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", {a, b, busy, done, pass, err_cnt, fail_vec}, 0);
        rst = 1'b0;
        sweep(4, 4, 0, 0, 0);

        // start held high: back-to-back sweeps every 4(S+1)+1 cycles
        gfun = 3'd1; d_sel = 3'd0;
        repeat (7) @(negedge clk);
        op = 3'd1; start = 1'b1;
        n = cyc;
        for (int i = 0; i < 3; i++)
            sbq.push_back(model(1, 1, 0, n + 1 + 4 * (S + 1) + i * (4 * (S + 1) + 1)));
        while (cyc < n + 3 * (4 * (S + 1) + 1)) @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 30; i++) begin
            int opv, g;
            opv = $urandom_range(0, 7);
            g   = ($urandom_range(0, 1) == 1 && opv <= 5) ? opv : $urandom_range(0, 7);
            sweep(opv, g, $urandom_range(0, S + 1), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sbq.size(), 0);
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
